flag_writer: RTL and testbench
==============================

// Module: flag_writer
// PURPOSE
//  Producer end of the Z/V/N flag interface consumed by branch/PC selection. Computes flags from
//  the EX-stage ALU result, holds the architectural flag register, and tracks in-flight flag-setting
//  instructions. Raises a stall when a branch needs flags that are not yet final.
//  Sits between the ALU (EX) and the decode-stage branch logic.
// PARAMETERS
//  MAX_INFLIGHT  2   max flag-setting instrs issued but not yet written (counter depth)
//  DW            16  ALU result width
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  issue_set    in   1      decode issues an instr whose opcode updates any flag
//  issue_rdy    out  1      low when pending == MAX_INFLIGHT; decode must hold issue_set
//  wr_en        in   1      EX result valid this cycle for a flag-setting instr
//  alu_op       in   4      opcode of the EX instr (alu_op_t)
//  alu_res      in   DW     ALU result
//  alu_ovfl     in   1      ALU signed overflow
//  flush        in   1      squash all issued-but-unwritten instrs
//  br_req       in   1      decode holds a conditional branch/branchreg needing flags
//  flags        out  3      {Z,V,N}: bit2=Z, bit1=V, bit0=N (same packing the PC logic reads)
//  flags_vld    out  1      flags are final for the requesting branch
//  br_stall     out  1      br_req && !flags_vld
// BEHAVIOUR
//  Reset: flag_q=3'b000, pending=0; outputs issue_rdy=1, flags=0, flags_vld=1, br_stall=0.
//  Flag calc: Z=(alu_res==0); N=alu_res[DW-1]; V=alu_ovfl.
//  Update mask by alu_op: ADD(0000)/SUB(0001) -> Z,V,N; XOR(0010)/SLL(0100)/SRA(0101)/ROR(0110)
//   -> Z only; RED(0011)/PADDSB(0111)/all others -> none (masked bits keep flag_q value).
//  Write: on wr_en, masked bits of flag_q take new values at next rising edge (1-cycle latency).
//  Pending counter: +1 on (issue_set && issue_rdy); -1 on wr_en; both same cycle -> unchanged.
//   wr_en with pending==0 is a protocol error: flags still written, counter saturates at 0.
//   issue_set with issue_rdy low is ignored (no increment).
//  Bypass: if pending==1 && wr_en, flags = merged new value combinationally, flags_vld=1.
//   pending==0 -> flags=flag_q, flags_vld=1. Otherwise flags=flag_q, flags_vld=0.
//  flags_vld/br_stall are independent of br_req except br_stall gating; purely combinational.
//  Flush: pending<=0 next edge; a wr_en in the flush cycle still updates flag_q (older instr in EX
//   commits); a same-cycle issue_set is dropped.
//  Reset mid-operation: async clear of flag_q and pending immediately, regardless of clk.
//  FSM view of counter: IDLE(0) / BUSY(1..MAX-1) / FULL(MAX); transitions only via rules above.
// STRUCTURE
//  cpu_pkg (shared): alu_op_t enum, condition_t enum (also used by PC logic), FLAG_Z=2, FLAG_V=1,
//   FLAG_N=0 index constants, flags_t packed struct {Z,V,N}.
//  Sub-module flag_calc: combinational {alu_op, alu_res, alu_ovfl} -> {new_flags, upd_mask}.
//  Top holds flag_q, pending counter, bypass mux, stall logic.
// TESTING
//  1 Reset: assert rst mid-cycle with pending=2 -> flags=000, pending=0, issue_rdy=1 immediately.
//  2 ADD: issue, then wr_en op=0000 res=16'h0000 ovfl=1 -> flags=3'b110 same cycle (bypass),
//    flag_q=110 next edge; then SUB res=16'h8000 ovfl=0 -> 3'b001.
//  3 Mask: flag_q=111, XOR res=16'h0001 -> 011; RED res=0 -> stays 011.
//  4 Stall: issue two ADDs (pending=2), br_req=1 -> br_stall=1; first wr_en -> still stalled;
//    second wr_en -> flags_vld=1, br_stall=0 that cycle.
//  5 Full/simul: pending=2, issue_set -> issue_rdy=0, no count; issue_set+wr_en at pending=1 -> 1.
//  6 Flush: pending=2, flush with wr_en SUB res=5 -> flag_q=000, pending=0, flags_vld=1 next.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU definitions used by the flag producer (flag_writer) and the
//   flag consumer (branch / PC selection).
//   Contents:
//     FLAG_Z/FLAG_V/FLAG_N : bit positions of each flag in the 3-bit flag word
//     alu_op_t             : EX-stage ALU opcode encoding
//     flags_t              : packed {Z,V,N} flag word (bit2=Z, bit1=V, bit0=N)
//     condition_t          : branch condition codes read by the PC logic
//     cnt_state_t          : coarse view of the in-flight flag-writer count
//     cond_met()           : evaluates a branch condition against a flag word
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_XOR    = 4'b0010,
        ALU_RED    = 4'b0011,
        ALU_SLL    = 4'b0100,
        ALU_SRA    = 4'b0101,
        ALU_ROR    = 4'b0110,
        ALU_PADDSB = 4'b0111
    } alu_op_t;

    // Field order gives Z at bit 2, V at bit 1, N at bit 0.
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    typedef enum logic [2:0] {
        COND_NE  = 3'b000,
        COND_EQ  = 3'b001,
        COND_GT  = 3'b010,
        COND_LT  = 3'b011,
        COND_GE  = 3'b100,
        COND_LE  = 3'b101,
        COND_OVF = 3'b110,
        COND_UNC = 3'b111
    } condition_t;

    typedef enum logic [1:0] {
        CNT_IDLE = 2'b00,   // nothing in flight, flag register is final
        CNT_BUSY = 2'b01,   // 1..MAX_INFLIGHT-1 writers in flight
        CNT_FULL = 2'b10    // decode must not issue another flag writer
    } cnt_state_t;

    function automatic logic cond_met(input condition_t cond, input flags_t f);
        logic taken;
        case (cond)
            COND_NE:  taken = !f.z;
            COND_EQ:  taken = f.z;
            COND_GT:  taken = !f.z && !f.n;
            COND_LT:  taken = f.n;
            COND_GE:  taken = f.z || !f.n;
            COND_LE:  taken = f.n || f.z;
            COND_OVF: taken = f.v;
            default:  taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/flag_calc.sv
// ----------------------------------------------------------------------------
// flag_calc
//   Purely combinational: derives candidate Z/V/N values from the EX-stage ALU
//   result and says which of them the current opcode is allowed to update.
//   Ports:
//     alu_op_i    in   4    EX opcode (alu_op_t encoding)
//     alu_res_i   in   DW   ALU result
//     alu_ovfl_i  in   1    ALU signed overflow
//     new_flags_o out  3    candidate {Z,V,N}
//     upd_mask_o  out  3    1 = that flag takes its candidate value
// ----------------------------------------------------------------------------
module flag_calc
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    alu_op_i,
    input  logic [DW-1:0] alu_res_i,
    input  logic          alu_ovfl_i,
    output flags_t        new_flags_o,
    output flags_t        upd_mask_o
);

    alu_op_t op;
    assign op = alu_op_t'(alu_op_i);

    always_comb begin
        new_flags_o.z = (alu_res_i == '0);
        new_flags_o.v = alu_ovfl_i;
        new_flags_o.n = alu_res_i[DW-1];
    end

    // NOTE: every variable written in an always_comb gets a value on every
    // path (default first), otherwise synthesis infers a latch.
    always_comb begin
        upd_mask_o = '0;
        case (op)
            ALU_ADD, ALU_SUB:                   upd_mask_o = 3'b111;
            ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: upd_mask_o.z = 1'b1;
            default:                            upd_mask_o = '0;  // RED, PADDSB, unused codes
        endcase
    end

endmodule

// File: rtl/flag_writer.sv
// ----------------------------------------------------------------------------
// flag_writer
//   Producer end of the Z/V/N flag interface. Holds the architectural flag
//   register, counts issued-but-unwritten flag-setting instructions, forwards
//   a same-cycle write when it is the only one outstanding, and stalls a
//   branch whose flags are not yet final.
//   Ports:
//     clk        in   1    rising-edge clock
//     rst        in   1    asynchronous active-high reset
//     issue_set  in   1    decode issues a flag-setting instruction
//     issue_rdy  out  1    low when MAX_INFLIGHT writers are outstanding
//     wr_en      in   1    EX result valid for a flag-setting instruction
//     alu_op     in   4    EX opcode (alu_op_t)
//     alu_res    in   DW   ALU result
//     alu_ovfl   in   1    ALU signed overflow
//     flush      in   1    squash all issued-but-unwritten instructions
//     br_req     in   1    decode holds a branch that needs flags
//     flags      out  3    {Z,V,N}
//     flags_vld  out  1    flags are final
//     br_stall   out  1    br_req && !flags_vld
// ----------------------------------------------------------------------------
module flag_writer
    import cpu_pkg::*;
#(
    parameter int MAX_INFLIGHT = 2,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_set,
    output logic          issue_rdy,
    input  logic          wr_en,
    input  logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_ovfl,
    input  logic          flush,
    input  logic          br_req,
    output logic [2:0]    flags,
    output logic          flags_vld,
    output logic          br_stall
);

    localparam int             CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    flags_t        flag_q, flag_d;
    logic [CW-1:0] pending_q, pending_d;

    flags_t        new_flags;
    flags_t        upd_mask;
    flags_t        merged;
    cnt_state_t    cnt_state;
    logic          do_issue;

    flag_calc #(.DW(DW)) u_flag_calc (
        .alu_op_i    (alu_op),
        .alu_res_i   (alu_res),
        .alu_ovfl_i  (alu_ovfl),
        .new_flags_o (new_flags),
        .upd_mask_o  (upd_mask)
    );

    // Flag word as it will look after this cycle's EX write lands.
    assign merged = (flag_q & ~upd_mask) | (new_flags & upd_mask);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q    <= '0;
            pending_q <= '0;
        end else begin
            flag_q    <= flag_d;
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    // An issue in a flush cycle belongs to the squashed stream and is dropped.
    assign do_issue = issue_set && issue_rdy && !flush;

    always_comb begin
        flag_d    = wr_en ? merged : flag_q;   // a write in a flush cycle is older and still commits
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else if (do_issue && !wr_en) begin
            pending_d = pending_q + CNT_ONE;
        end else if (wr_en && !do_issue && (cnt_state != CNT_IDLE)) begin
            // A write with nothing outstanding is a protocol error; hold at 0.
            pending_d = pending_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        if (pending_q == '0)
            cnt_state = CNT_IDLE;
        else if (pending_q >= CNT_MAX)
            cnt_state = CNT_FULL;
        else
            cnt_state = CNT_BUSY;

        issue_rdy = (cnt_state != CNT_FULL);

        flags     = flag_q;
        flags_vld = 1'b0;
        if (cnt_state == CNT_IDLE) begin
            flags_vld = 1'b1;
        end else if ((pending_q == CNT_ONE) && wr_en) begin
            // The only outstanding writer is in EX now: forward its result.
            flags     = merged;
            flags_vld = 1'b1;
        end

        br_stall = br_req && !flags_vld;
    end

endmodule

// File: tb/tb_flag_writer.sv
// ----------------------------------------------------------------------------
// tb_flag_writer
//   Directed self-checking bench for flag_writer. Inputs change 1 ns after a
//   rising edge; outputs are sampled mid-cycle, before the next edge.
// ----------------------------------------------------------------------------
module tb_flag_writer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_set;
    logic        issue_rdy;
    logic        wr_en;
    logic [3:0]  alu_op;
    logic [15:0] alu_res;
    logic        alu_ovfl;
    logic        flush;
    logic        br_req;
    logic [2:0]  flags;
    logic        flags_vld;
    logic        br_stall;

    int checks = 0;
    int errors = 0;

    flag_writer #(.MAX_INFLIGHT(2), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_set (issue_set),
        .issue_rdy (issue_rdy),
        .wr_en     (wr_en),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .alu_ovfl  (alu_ovfl),
        .flush     (flush),
        .br_req    (br_req),
        .flags     (flags),
        .flags_vld (flags_vld),
        .br_stall  (br_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [3:0] op, input logic [15:0] res,
                          input logic ovfl);
        wr_en    = en;
        alu_op   = op;
        alu_res  = res;
        alu_ovfl = ovfl;
    endtask

    // Issue one flag writer, then write it back; checks the bypass value in
    // the write cycle and the registered value afterwards.
    task automatic issue_and_write(input string tag, input logic [3:0] op,
                                   input logic [15:0] res, input logic ovfl,
                                   input logic [2:0] exp);
        issue_set = 1'b1;
        tick();
        issue_set = 1'b0;
        #2;
        check({tag, "_pend_vld"}, 16'(flags_vld), 16'h0);
        set_wr(1'b1, op, res, ovfl);
        #1;
        check({tag, "_byp"}, 16'(flags), 16'(exp));
        check({tag, "_byp_vld"}, 16'(flags_vld), 16'h1);
        tick();
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        #2;
        check({tag, "_reg"}, 16'(flags), 16'(exp));
        check({tag, "_reg_vld"}, 16'(flags_vld), 16'h1);
    endtask

    initial begin
        rst       = 1'b1;
        issue_set = 1'b0;
        flush     = 1'b0;
        br_req    = 1'b0;
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        #12;
        rst = 1'b0;
        tick();

        // Reset state
        br_req = 1'b1;
        #2;
        check("rst_flags", 16'(flags), 16'h0);
        check("rst_vld", 16'(flags_vld), 16'h1);
        check("rst_rdy", 16'(issue_rdy), 16'h1);
        check("rst_stall", 16'(br_stall), 16'h0);
        br_req = 1'b0;

        // Flag calculation and update masks; expected {Z,V,N} computed by hand
        issue_and_write("add0",  4'h0, 16'h0000, 1'b1, 3'b110);
        issue_and_write("sub",   4'h1, 16'h8000, 1'b0, 3'b001);
        issue_and_write("xor",   4'h2, 16'h0000, 1'b1, 3'b101); // only Z moves
        issue_and_write("red",   4'h3, 16'h8000, 1'b1, 3'b101); // nothing moves
        issue_and_write("sll",   4'h4, 16'h0001, 1'b1, 3'b001);
        issue_and_write("opF",   4'hF, 16'h0000, 1'b1, 3'b001); // unused opcode
        issue_and_write("add1",  4'h0, 16'h8000, 1'b1, 3'b011);

        // Stall with two in flight, and full-counter behaviour
        issue_set = 1'b1;
        tick();
        tick();
        issue_set = 1'b0;
        #2;
        check("full_nostall_noreq", 16'(br_stall), 16'h0);
        br_req = 1'b1;
        #1;
        check("full_stall", 16'(br_stall), 16'h1);
        check("full_rdy", 16'(issue_rdy), 16'h0);
        check("full_flags", 16'(flags), 16'h3);
        issue_set = 1'b1;                       // must be ignored
        tick();
        issue_set = 1'b0;
        #2;
        check("full_hold_rdy", 16'(issue_rdy), 16'h0);
        set_wr(1'b1, 4'h0, 16'h0000, 1'b0);     // ADD -> 100, not forwarded at pending 2
        #1;
        check("wr1_stall", 16'(br_stall), 16'h1);
        check("wr1_flags", 16'(flags), 16'h3);
        tick();
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        #2;
        check("p1_stall", 16'(br_stall), 16'h1);
        check("p1_flags", 16'(flags), 16'h4);
        check("p1_rdy", 16'(issue_rdy), 16'h1);
        issue_set = 1'b1;                       // issue + write together keeps pending at 1
        set_wr(1'b1, 4'h1, 16'h0001, 1'b1);     // SUB -> 010
        #1;
        check("simul_byp", 16'(flags), 16'h2);
        check("simul_stall", 16'(br_stall), 16'h0);
        tick();
        issue_set = 1'b0;
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        #2;
        check("simul_p1_vld", 16'(flags_vld), 16'h0);
        check("simul_p1_stall", 16'(br_stall), 16'h1);
        set_wr(1'b1, 4'h2, 16'h0000, 1'b0);     // XOR -> Z set -> 110
        #1;
        check("wr2_flags", 16'(flags), 16'h6);
        check("wr2_stall", 16'(br_stall), 16'h0);
        tick();
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        br_req = 1'b0;
        #2;
        check("drain_flags", 16'(flags), 16'h6);
        check("drain_vld", 16'(flags_vld), 16'h1);

        // Write with nothing outstanding: flags still written, count stays 0
        set_wr(1'b1, 4'h0, 16'h8000, 1'b0);     // ADD -> 001
        #1;
        check("perr_nobyp", 16'(flags), 16'h6);
        tick();
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        #2;
        check("perr_flags", 16'(flags), 16'h1);
        check("perr_vld", 16'(flags_vld), 16'h1);
        issue_set = 1'b1;
        tick();
        issue_set = 1'b0;
        #2;
        check("perr_p1_vld", 16'(flags_vld), 16'h0);
        check("perr_p1_rdy", 16'(issue_rdy), 16'h1);

        // Flush at pending 2 with a committing write and a dropped issue
        issue_set = 1'b1;
        tick();
        #2;
        check("fl_pre_rdy", 16'(issue_rdy), 16'h0);
        flush = 1'b1;
        set_wr(1'b1, 4'h1, 16'h0005, 1'b0);     // SUB -> 000
        #1;
        check("fl_cyc_flags", 16'(flags), 16'h1);
        check("fl_cyc_vld", 16'(flags_vld), 16'h0);
        tick();
        flush     = 1'b0;
        issue_set = 1'b0;
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        #2;
        check("fl_flags", 16'(flags), 16'h0);
        check("fl_vld", 16'(flags_vld), 16'h1);
        check("fl_rdy", 16'(issue_rdy), 16'h1);
        issue_set = 1'b1;
        tick();
        issue_set = 1'b0;
        #2;
        check("fl_after_rdy", 16'(issue_rdy), 16'h1);
        check("fl_after_vld", 16'(flags_vld), 16'h0);

        // Asynchronous reset mid-cycle with pending 2 and non-zero flags
        set_wr(1'b1, 4'h0, 16'h0000, 1'b1);     // ADD -> 110, pending 1 -> 0
        tick();
        set_wr(1'b0, 4'h0, 16'h0, 1'b0);
        issue_set = 1'b1;
        tick();
        tick();
        issue_set = 1'b0;
        #2;
        check("ar_pre_flags", 16'(flags), 16'h6);
        check("ar_pre_rdy", 16'(issue_rdy), 16'h0);
        rst = 1'b1;
        #1;
        check("ar_flags", 16'(flags), 16'h0);
        check("ar_vld", 16'(flags_vld), 16'h1);
        check("ar_rdy", 16'(issue_rdy), 16'h1);
        #2;
        rst = 1'b0;
        tick();
        #2;
        check("ar_post_flags", 16'(flags), 16'h0);
        check("ar_post_vld", 16'(flags_vld), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
